neuron_acc: RTL and testbench



---
 rtl/neuron_acc_if.sv | 26 ++
 rtl/neuron_acc.sv | 135 +++++++++++++
 tb/tb_neuron_acc.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/neuron_acc_if.sv
// Handshake bundle between the MAC valid pipe / control and neuron_acc.
// master drives the neuron request and partial sums; slave is the accumulator.
interface neuron_acc_if #(
    parameter int IN_W   = 20,
    parameter int BIAS_W = 16,
    parameter int OUT_W  = 8
);
    logic              start;
    logic [BIAS_W-1:0] bias;
    logic [IN_W-1:0]   sum_in;
    logic              sum_valid;
    logic [OUT_W-1:0]  out_data;
    logic              out_valid;
    logic              busy;
    logic              overrun;

    modport master (
        output start, bias, sum_in, sum_valid,
        input  out_data, out_valid, busy, overrun
    );

    modport slave (
        input  start, bias, sum_in, sum_valid,
        output out_data, out_valid, busy, overrun
    );
endinterface

// File: rtl/neuron_acc.sv
// Per-neuron accumulator: sums MAC partial sums, adds bias,
// applies ReLU and a rescale/saturate into an activation.
module neuron_acc #(
    parameter int CHUNKS = 49,
    parameter int IN_W   = 20,
    parameter int ACC_W  = 26,
    parameter int BIAS_W = 16,
    parameter int SHIFT  = 8,
    parameter int OUT_W  = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    neuron_acc_if.slave bus
);

    localparam int CNT_W = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CHUNKS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCUM,
        S_BIAS,
        S_ACT
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [ACC_W-1:0]    r_acc;
    logic [CNT_W-1:0]    r_cnt;
    logic [BIAS_W-1:0]   r_bias;
    logic signed [ACC_W:0] r_biased;
    logic [OUT_W-1:0]    r_out;
    logic                r_valid;
    logic                r_ovr;

    logic                w_take;
    logic                w_sum;
    logic signed [ACC_W:0] w_acc_ext;
    logic signed [ACC_W:0] w_bias_ext;
    logic signed [ACC_W:0] w_shift;
    logic                w_sat;

    // The accumulator is a magnitude that may use its top bit,
    // so it is widened with a zero, not its MSB.
    assign w_acc_ext  = $signed({1'b0, r_acc});
    assign w_bias_ext = $signed({{(ACC_W + 1 - BIAS_W){r_bias[BIAS_W-1]}}, r_bias});
    assign w_shift    = r_biased >>> SHIFT;
    assign w_sat      = |w_shift[ACC_W:OUT_W];

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state plus accept strobes for start and partial sums
    always_comb begin
        w_next = r_state;
        w_take = 1'b0;
        w_sum  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_take = 1'b1;
                    w_next = S_ACCUM;
                end
            end
            S_ACCUM: begin
                if (bus.sum_valid) begin
                    w_sum = 1'b1;
                    if (r_cnt == CNT_LAST) begin
                        w_next = S_BIAS;
                    end
                end
            end
            S_BIAS:  w_next = S_ACT;
            S_ACT:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Accumulate, bias and activation datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc    <= '0;
            r_cnt    <= '0;
            r_bias   <= '0;
            r_biased <= '0;
            r_out    <= '0;
            r_valid  <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            if (w_take) begin
                r_acc  <= '0;
                r_cnt  <= '0;
                r_bias <= bus.bias;
            end
            if (w_sum) begin
                r_acc <= r_acc + {{(ACC_W - IN_W){1'b0}}, bus.sum_in};
                r_cnt <= r_cnt + 1'b1;
            end
            if (r_state == S_BIAS) begin
                r_biased <= w_acc_ext + w_bias_ext;
            end
            if (r_state == S_ACT) begin
                r_valid <= 1'b1;
                if (r_biased[ACC_W]) begin
                    r_out <= '0;
                end else if (w_sat) begin
                    r_out <= '1;
                end else begin
                    r_out <= w_shift[OUT_W-1:0];
                end
            end
        end
    end

    // Sticky flag for sums arriving when no neuron is collecting
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovr <= 1'b0;
        end else if (bus.sum_valid && (r_state != S_ACCUM)) begin
            r_ovr <= 1'b1;
        end
    end

    assign bus.out_data  = r_out;
    assign bus.out_valid = r_valid;
    assign bus.busy      = (r_state != S_IDLE);
    assign bus.overrun   = r_ovr;

endmodule

// File: tb/tb_neuron_acc.sv
// Bench for neuron_acc: transaction-level reference model checked
// every cycle, plus literal expectations for the worked examples.
module tb_neuron_acc;

    localparam int CHUNKS = 49;
    localparam int IN_W   = 20;
    localparam int ACC_W  = 26;
    localparam int BIAS_W = 16;
    localparam int SHIFT  = 8;
    localparam int OUT_W  = 8;

    logic clk;
    logic rst_n;

    neuron_acc_if #(.IN_W(IN_W), .BIAS_W(BIAS_W), .OUT_W(OUT_W)) bus ();

    neuron_acc #(
        .CHUNKS(CHUNKS), .IN_W(IN_W), .ACC_W(ACC_W),
        .BIAS_W(BIAS_W), .SHIFT(SHIFT), .OUT_W(OUT_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Activation from a raw dot-product total and bias, plain arithmetic
    function automatic longint act_of(input longint total, input longint b);
        longint v;
        v = total + b;
        if (v < 0) v = 0;
        else v = v / (longint'(1) << SHIFT);
        if (v > (longint'(1) << OUT_W) - 1) v = (longint'(1) << OUT_W) - 1;
        return v;
    endfunction

    // Reference model: a neuron is "collecting" until CHUNKS sums have
    // been taken; its result appears two edges after the last sum.
    int     cyc    = 0;
    bit     m_coll = 0;
    int     m_n    = 0;
    longint m_tot  = 0;
    longint m_b    = 0;
    int     m_due  = -10;
    bit     e_v    = 0;
    bit     e_busy = 0;
    bit     e_ovr  = 0;
    longint e_data = 0;

    always @(posedge clk or negedge rst_n) begin
        bit idle;
        if (!rst_n) begin
            cyc = 0; m_coll = 0; m_n = 0; m_tot = 0; m_b = 0;
            m_due = -10; e_v = 0; e_busy = 0; e_ovr = 0; e_data = 0;
        end else begin
            cyc++;
            idle = !m_coll && (cyc > m_due);
            e_v = 0;
            if (bus.sum_valid && !m_coll) begin
                e_ovr = 1;
            end else if (bus.sum_valid) begin
                m_tot += longint'(bus.sum_in);
                m_n++;
                if (m_n == CHUNKS) begin
                    m_coll = 0;
                    m_due  = cyc + 2;
                end
            end
            if (cyc == m_due) begin
                e_v    = 1;
                e_data = act_of(m_tot, m_b);
            end
            if (idle && bus.start) begin
                m_coll = 1; m_n = 0; m_tot = 0;
                m_b = longint'($signed(bus.bias));
            end
            e_busy = m_coll || (cyc < m_due);
        end
    end

    // Compare DUT to model every cycle, away from the rising edge
    always @(negedge clk) begin
        if (rst_n) begin
            chk("out_valid", longint'(bus.out_valid), longint'(e_v));
            chk("busy", longint'(bus.busy), longint'(e_busy));
            chk("overrun", longint'(bus.overrun), longint'(e_ovr));
            chk("out_data", longint'(bus.out_data), e_data);
        end
    end

    // One neuron: start now (at a falling edge), feed CHUNKS sums with
    // optional gaps, then wait boundedly for the result pulse.
    task automatic run_neuron(input int rnd, input int val, input int bias_v,
                              input int gap_pct, input bit mid_start,
                              output int data, output int lat);
        int k;
        bit found;
        bus.start = 1'b1;
        bus.bias  = BIAS_W'(bias_v);
        @(negedge clk);
        bus.start = 1'b0;
        for (int i = 0; i < CHUNKS; i++) begin
            while ($urandom_range(99) < gap_pct) @(negedge clk);
            bus.sum_in    = rnd ? IN_W'($urandom_range(val)) : IN_W'(val);
            bus.sum_valid = 1'b1;
            if (mid_start && i == 10) begin
                bus.start = 1'b1;
                bus.bias  = 16'h7fff;
            end
            @(negedge clk);
            bus.sum_valid = 1'b0;
            bus.start     = 1'b0;
        end
        k     = cyc;
        found = 0;
        data  = -1;
        lat   = -1;
        for (int t = 0; t < 8; t++) begin
            if (bus.out_valid) begin
                found = 1;
                data  = int'(bus.out_data);
                lat   = cyc - k;
                break;
            end
            @(negedge clk);
        end
        if (!found) begin
            n_chk++;
            n_fail++;
            $display("FAIL result_timeout: no out_valid within 8 cycles");
        end
    endtask

    int d;
    int l;

    initial begin
        rst_n         = 1'b1;
        bus.start     = 1'b0;
        bus.bias      = '0;
        bus.sum_in    = '0;
        bus.sum_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_out_data", longint'(bus.out_data), 0);
        chk("rst_out_valid", longint'(bus.out_valid), 0);
        chk("rst_busy", longint'(bus.busy), 0);
        chk("rst_overrun", longint'(bus.overrun), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run_neuron(0, 1000, 0, 0, 0, d, l);
        chk("nominal_data", d, 191);
        chk("nominal_edge_offset", l, 2);

        run_neuron(0, 10, -100, 30, 0, d, l);
        chk("bias_gaps_data", d, 1);
        chk("bias_gaps_edge_offset", l, 2);

        run_neuron(0, 0, -5, 0, 0, d, l);
        chk("relu_data", d, 0);

        run_neuron(0, 20'hFFFFF, 0, 10, 0, d, l);
        chk("saturate_data", d, 255);

        run_neuron(0, 1000, 0, 20, 1, d, l);
        chk("ignored_start_data", d, 191);
        chk("overrun_after_ignored_start", longint'(bus.overrun), 0);

        @(negedge clk);
        bus.sum_valid = 1'b1;
        bus.sum_in    = 20'd5;
        @(negedge clk);
        bus.sum_valid = 1'b0;
        chk("overrun_set", longint'(bus.overrun), 1);
        repeat (3) @(negedge clk);

        run_neuron(0, 10, -100, 0, 0, d, l);
        chk("b2b_first_data", d, 1);
        run_neuron(0, 1000, 0, 0, 0, d, l);
        chk("b2b_second_data", d, 191);
        chk("b2b_second_edge_offset", l, 2);

        for (int r = 0; r < 6; r++) begin
            run_neuron(1, 2000, int'($urandom_range(65535)) - 32768,
                       r * 10, 0, d, l);
            chk("random_edge_offset", l, 2);
        end
        chk("overrun_sticky", longint'(bus.overrun), 1);

        @(negedge clk);
        bus.start = 1'b1;
        bus.bias  = '0;
        @(negedge clk);
        bus.start = 1'b0;
        for (int i = 0; i < 20; i++) begin
            bus.sum_in    = 20'd1000;
            bus.sum_valid = 1'b1;
            @(negedge clk);
        end
        bus.sum_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_out_data", longint'(bus.out_data), 0);
        chk("midrst_out_valid", longint'(bus.out_valid), 0);
        chk("midrst_busy", longint'(bus.busy), 0);
        chk("midrst_overrun", longint'(bus.overrun), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run_neuron(0, 1000, 0, 0, 0, d, l);
        chk("post_reset_data", d, 191);
        chk("post_reset_edge_offset", l, 2);

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
